// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants shared by the timing generator and renderers
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b0;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_bits_t;

  function automatic logic in_window(input cnt_t c, input int lo, input int len);
    return (c >= cnt_t'(lo)) && (c < cnt_t'(lo + len));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster counts, renderer colour return and VGA pins
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic pix_en;
  cnt_t hcount;
  cnt_t vcount;
  logic line_tick;
  logic frame_tick;
  logic r_in;
  logic g_in;
  logic b_in;
  logic hsync;
  logic vsync;
  logic video_on;
  logic r_out;
  logic g_out;
  logic b_out;

  modport master (
    output pix_en, hcount, vcount, line_tick, frame_tick,
    output hsync, vsync, video_on, r_out, g_out, b_out,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  pix_en, hcount, vcount, line_tick, frame_tick,
    input  hsync, vsync, video_on, r_out, g_out, b_out,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - DEPTH-stage clk shift register with a loadable reset value
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val_i;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, sync decode and renderer-aligned VGA pin registers
module vga_timing_gen #(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL,
  parameter int   CLK_DIV  = 2,
  parameter int   PIPE_DLY = 1
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vga
);
  import vga_pkg::cnt_t;
  import vga_pkg::sync_bits_t;
  import vga_pkg::in_window;

  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam int   DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam sync_bits_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, act: 1'b0};

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             run_q;
  cnt_t             hcount_q, hcount_d;
  cnt_t             vcount_q, vcount_d;
  logic             pix_en, line_end, frame_end;
  sync_bits_t       raw, dly;
  logic             hsync_q, vsync_q, video_on_q;
  logic             r_q, g_q, b_q;

  // run_q keeps pix_en low for the reset cycle even when CLK_DIV=1 pins div_cnt at its last value
  always_comb begin
    pix_en    = run_q && (div_cnt_q == DIV_LAST);
    line_end  = pix_en && (hcount_q == H_LAST);
    frame_end = line_end && (vcount_q == V_LAST);
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (pix_en) begin
      hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
      if (line_end) vcount_d = frame_end ? '0 : vcount_q + 1'b1;
    end
    raw.hs  = in_window(hcount_q, H_ACTIVE + H_FP, H_SYNC);
    raw.vs  = in_window(vcount_q, V_ACTIVE + V_FP, V_SYNC);
    raw.act = (hcount_q < cnt_t'(H_ACTIVE)) && (vcount_q < cnt_t'(V_ACTIVE));
  end

  sync_delay_line #(
    .WIDTH ($bits(sync_bits_t)),
    .DEPTH (PIPE_DLY)
  ) u_sync_dly (
    .clk       (clk),
    .rst       (rst),
    .rst_val_i (SYNC_IDLE),
    .d_i       (raw),
    .q_o       (dly)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      run_q      <= 1'b0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      video_on_q <= 1'b0;
      r_q        <= 1'b0;
      g_q        <= 1'b0;
      b_q        <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      run_q      <= 1'b1;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      hsync_q    <= dly.hs ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= dly.vs ? SYNC_POL : ~SYNC_POL;
      video_on_q <= dly.act;
      r_q        <= vga.r_in & dly.act;
      g_q        <= vga.g_in & dly.act;
      b_q        <= vga.b_in & dly.act;
    end
  end

  assign vga.pix_en     = pix_en;
  assign vga.hcount     = hcount_q;
  assign vga.vcount     = vcount_q;
  assign vga.line_tick  = line_end;
  assign vga.frame_tick = frame_end;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.r_out      = r_q;
  assign vga.g_out      = g_q;
  assign vga.b_out      = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: full 640x480 line timing plus two reduced-size rasters
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  vga_timing_gen_if f_if ();
  vga_timing_gen_if s_if ();
  vga_timing_gen_if c_if ();

  vga_timing_gen u_full (
    .clk (clk),
    .rst (rst),
    .vga (f_if.master)
  );

  // 25x12 raster (hsync 18..21, vsync lines 8..9), 2 clk/pixel, 1-clk renderer
  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (2),
    .CLK_DIV  (2),  .PIPE_DLY (1)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .vga (s_if.master)
  );

  // same raster, 1 clk/pixel, no renderer latency, active-high sync
  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b1), .CLK_DIV (1), .PIPE_DLY (0)
  ) u_div1 (
    .clk (clk),
    .rst (rst),
    .vga (c_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // registered renderer lighting pixel (5,3) on the small raster
  always @(posedge clk) s_if.r_in <= (s_if.hcount == 10'd5) && (s_if.vcount == 10'd3);

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return f_if.line_tick;
      1:       return f_if.hsync;
      2:       return f_if.hcount == 10'd656;
      3:       return s_if.frame_tick;
      4:       return s_if.vsync;
      5:       return (s_if.vcount == 10'd8) && (s_if.hcount == 10'd0);
      6:       return (s_if.vcount == 10'd9) && (s_if.hcount == 10'd3);
      7:       return c_if.line_tick;
      8:       return c_if.hcount == 10'd18;
      9:       return c_if.hsync;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input logic val, output int t);
    int n = 0;
    while (probe(which) !== val && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(probe(which)), int'(val));
    t = cyc;
  endtask

  initial begin
    int t0, t1, t2, t3, tf, n, nr, ng, nb, nvid, nbad, nfall;
    int hp1, hp2, vp1, vp2, rh, rv, rvid;
    logic prev_vs, seen;

    rst = 1'b1;
    f_if.r_in = 1'b1; f_if.g_in = 1'b0; f_if.b_in = 1'b0;
    s_if.g_in = 1'b1; s_if.b_in = 1'b0;
    c_if.r_in = 1'b1; c_if.g_in = 1'b0; c_if.b_in = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_hcount",   f_if.hcount, 0);
    chk("rst_vcount",   f_if.vcount, 0);
    chk("rst_hsync",    f_if.hsync, 1);
    chk("rst_vsync",    f_if.vsync, 1);
    chk("rst_video_on", f_if.video_on, 0);
    chk("rst_r_out",    f_if.r_out, 0);
    chk("rst_pix_en",   f_if.pix_en, 0);
    chk("rst_line",     f_if.line_tick, 0);
    chk("rst_pix_en_div1", c_if.pix_en, 0);
    chk("rst_hsync_pol1",  c_if.hsync, 0);
    rst = 1'b0;

    n = 0;
    repeat (10) begin @(negedge clk); n += int'(f_if.pix_en); end
    chk("pix_en_div2", n, 5);

    wait_for("line_a", 0, 1'b1, t1);
    @(negedge clk);
    wait_for("line_b", 0, 1'b1, t2);
    chk("line_period", t2 - t1, 1600);

    wait_for("h656", 2, 1'b1, t0);
    wait_for("hs_fall", 1, 1'b0, t1);
    chk("hs_latency", t1 - t0, 2);
    wait_for("hs_rise", 1, 1'b1, t2);
    chk("hs_width", t2 - t1, 192);
    wait_for("hs_fall2", 1, 1'b0, t3);
    chk("hs_period", t3 - t1, 1600);

    wait_for("line_c", 0, 1'b1, t0);
    nr = 0; nvid = 0; nbad = 0;
    repeat (1600) begin
      @(negedge clk);
      nr   += int'(f_if.r_out);
      nvid += int'(f_if.video_on);
      if (f_if.r_out && !f_if.video_on) nbad++;
    end
    chk("full_r_clks", nr, 1280);
    chk("full_video_clks", nvid, 1280);
    chk("full_r_blank", nbad, 0);

    wait_for("s_frame_a", 3, 1'b1, t0);
    tf = 0; nr = 0; ng = 0; nb = 0; nbad = 0; nfall = 0; seen = 1'b0;
    rh = -1; rv = -1; rvid = -1;
    hp1 = 0; hp2 = 0; vp1 = 0; vp2 = 0;
    prev_vs = s_if.vsync;
    repeat (600) begin
      @(negedge clk);
      if (s_if.frame_tick && tf == 0) tf = cyc;
      if (prev_vs && !s_if.vsync) nfall++;
      prev_vs = s_if.vsync;
      nr += int'(s_if.r_out);
      ng += int'(s_if.g_out);
      nb += int'(s_if.b_out);
      if ((s_if.r_out || s_if.g_out) && !s_if.video_on) nbad++;
      if (s_if.r_out && !seen) begin
        seen = 1'b1; rh = hp2; rv = vp2; rvid = int'(s_if.video_on);
      end
      hp2 = hp1; hp1 = int'(s_if.hcount);
      vp2 = vp1; vp1 = int'(s_if.vcount);
    end
    chk("s_frame_period", tf - t0, 600);
    chk("s_vs_falls", nfall, 1);
    chk("s_r_clks", nr, 2);
    chk("s_r_hcount", rh, 5);
    chk("s_r_vcount", rv, 3);
    chk("s_r_video_on", rvid, 1);
    chk("s_g_clks", ng, 192);
    chk("s_b_clks", nb, 0);
    chk("s_blank_colour", nbad, 0);

    wait_for("s_v8", 5, 1'b1, t0);
    wait_for("s_vs_fall", 4, 1'b0, t1);
    chk("s_vs_latency", t1 - t0, 2);
    wait_for("s_vs_rise", 4, 1'b1, t2);
    chk("s_vs_width", t2 - t1, 100);

    wait_for("s_v9", 6, 1'b1, t0);
    chk("s_vs_mid", s_if.vsync, 0);
    rst = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk("s_rst_vsync", s_if.vsync, 1);
    chk("s_rst_hcount", s_if.hcount, 0);
    chk("s_rst_vcount", s_if.vcount, 0);
    rst = 1'b0;
    wait_for("s_vs_after_rst", 4, 1'b0, t1);
    chk("s_vs_after_rst_dly", t1 - t0, 402);

    n = 0;
    repeat (30) begin @(negedge clk); n += int'(c_if.pix_en); end
    chk("pix_en_div1", n, 30);
    wait_for("c_h18", 8, 1'b1, t0);
    wait_for("c_hs_assert", 9, 1'b1, t1);
    chk("c_hs_latency", t1 - t0, 1);
    wait_for("c_hs_deassert", 9, 1'b0, t2);
    chk("c_hs_width", t2 - t1, 4);
    wait_for("c_line_a", 7, 1'b1, t1);
    @(negedge clk);
    wait_for("c_line_b", 7, 1'b1, t2);
    chk("c_line_period", t2 - t1, 25);
    nr = 0; nbad = 0;
    repeat (300) begin
      @(negedge clk);
      nr += int'(c_if.r_out);
      if (c_if.r_out && !c_if.video_on) nbad++;
    end
    chk("c_r_clks", nr, 96);
    chk("c_r_blank", nbad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
